sobel_frame_ctrl: RTL

- Frame-level controller for the Sobel edge stage.
- Holds the runtime configuration (threshold, enable) and applies updates only at frame boundaries, so a frame is never processed with mixed settings.
- Monitors the Sobel output stream and produces per-frame statistics: edge-pixel count, line width, line count.
- Detects malformed or stalled frames.
- Sits between the register/control bus and the Sobel edge stage, tapping that stage's post_* outputs.

---
 rtl/sobel_frame_ctrl_pkg.sv | 18 +
 rtl/sobel_stream_edge_det.sv | 30 +++
 rtl/sobel_frame_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared constants and FSM encoding for the Sobel frame-level controller
// and the stream monitors built around it.
package sobel_frame_ctrl_pkg;

    localparam int THR_W             = 11;
    localparam int DEFAULT_THRESHOLD = 128;
    localparam int H_W               = 12;
    localparam int V_W               = 12;
    localparam int CNT_W             = 24;
    localparam int TIMEOUT_CYC       = 2**24 - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRAME  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_stream_edge_det.sv
// Registered edge detection on the Sobel stream sync signals: one-cycle
// pulses, valid the cycle after the vsync rise / href fall.
module sobel_stream_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vsync_rise,
    output logic href_fall
);

    logic vsync_d_r;
    logic href_d_r;

    // Delay line and edge pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d_r  <= 1'b0;
            href_d_r   <= 1'b0;
            vsync_rise <= 1'b0;
            href_fall  <= 1'b0;
        end else begin
            vsync_d_r  <= vsync;
            href_d_r   <= href;
            vsync_rise <= vsync & ~vsync_d_r;
            href_fall  <= ~href & href_d_r;
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the Sobel edge stage: frame-synchronous config
// updates, per-frame statistics and geometry/timeout error detection.
module sobel_frame_ctrl #(
    parameter int THR_W             = sobel_frame_ctrl_pkg::THR_W,
    parameter int DEFAULT_THRESHOLD = sobel_frame_ctrl_pkg::DEFAULT_THRESHOLD,
    parameter int H_W               = sobel_frame_ctrl_pkg::H_W,
    parameter int V_W               = sobel_frame_ctrl_pkg::V_W,
    parameter int CNT_W             = sobel_frame_ctrl_pkg::CNT_W,
    parameter int TIMEOUT_CYC       = sobel_frame_ctrl_pkg::TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [THR_W-1:0] cfg_thr,
    input  logic             cfg_en,
    output logic [THR_W-1:0] thr_out,
    output logic             en_out,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_clken,
    input  logic             in_edge,
    output logic             stat_valid,
    output logic [CNT_W-1:0] stat_edges,
    output logic [H_W-1:0]   stat_width,
    output logic [V_W-1:0]   stat_height,
    output logic             err_geom,
    output logic             err_timeout,
    input  logic             err_clr
);

    import sobel_frame_ctrl_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state_r, state_s;
    logic               fs_s, hfall_s;
    logic               pend_r;
    logic [THR_W-1:0]   pend_thr_r;
    logic               pend_en_r;
    logic               xfer_s, apply_s;
    logic [H_W-1:0]     pix_cnt_r, pix_s, width_r, width_s;
    logic [CNT_W-1:0]   edge_cnt_r, edge_s;
    logic [V_W-1:0]     line_cnt_r, line_s;
    logic [TMO_W-1:0]   tmo_cnt_r, tmo_s;
    logic               geom_evt_s, tmo_evt_s, stat_load_s, active_s, frame_s;

    sobel_stream_edge_det u_edge_det (
        .clk        (clk),
        .rst        (rst),
        .vsync      (in_vsync),
        .href       (in_href),
        .vsync_rise (fs_s),
        .href_fall  (hfall_s)
    );

    assign xfer_s  = cfg_valid & cfg_ready;
    // pend_r is never set in a transfer cycle, so a same-cycle transfer waits
    assign apply_s = fs_s & pend_r;

    // Next-state and frame-event decode
    always_comb begin
        state_s     = state_r;
        stat_load_s = 1'b0;
        tmo_evt_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                state_s = fs_s ? S_FRAME : S_IDLE;
            end
            S_FRAME: begin
                if (fs_s) begin
                    state_s = S_REPORT;
                end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC)) begin
                    state_s   = S_IDLE;
                    tmo_evt_s = 1'b1;
                end else begin
                    state_s = S_FRAME;
                end
            end
            S_REPORT: begin
                state_s     = S_FRAME;
                stat_load_s = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Counter next values; the report cycle restarts from zero and counts into the new frame
    always_comb begin
        frame_s    = (state_r == S_FRAME);
        active_s   = (state_r != S_IDLE);
        pix_s      = frame_s ? pix_cnt_r  : '0;
        edge_s     = frame_s ? edge_cnt_r : '0;
        line_s     = frame_s ? line_cnt_r : '0;
        width_s    = frame_s ? width_r    : '0;
        geom_evt_s = 1'b0;
        tmo_s      = (frame_s && !fs_s) ? tmo_cnt_r + TMO_W'(1) : '0;
        if (active_s && hfall_s && (pix_s != '0)) begin
            if (line_s == '0) begin
                width_s = pix_s;
            end else begin
                geom_evt_s = (pix_s != width_s);
            end
            line_s = (line_s == '1) ? line_s : line_s + V_W'(1);
            pix_s  = '0;
        end else begin
            pix_s = pix_s;
        end
        if (active_s && in_clken && in_href) begin
            pix_s  = pix_s + H_W'(1);
            edge_s = (in_edge && (edge_s != '1)) ? edge_s + CNT_W'(1) : edge_s;
        end else begin
            edge_s = edge_s;
        end
    end

    // State, counters, configuration, statistics and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            pix_cnt_r   <= '0;
            edge_cnt_r  <= '0;
            line_cnt_r  <= '0;
            width_r     <= '0;
            tmo_cnt_r   <= '0;
            pend_r      <= 1'b0;
            pend_thr_r  <= '0;
            pend_en_r   <= 1'b0;
            cfg_ready   <= 1'b1;
            thr_out     <= THR_W'(DEFAULT_THRESHOLD);
            en_out      <= 1'b1;
            stat_valid  <= 1'b0;
            stat_edges  <= '0;
            stat_width  <= '0;
            stat_height <= '0;
            err_geom    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_r    <= state_s;
            pix_cnt_r  <= pix_s;
            edge_cnt_r <= edge_s;
            line_cnt_r <= line_s;
            width_r    <= width_s;
            tmo_cnt_r  <= tmo_s;
            if (xfer_s) begin
                pend_r     <= 1'b1;
                pend_thr_r <= cfg_thr;
                pend_en_r  <= cfg_en;
            end else if (apply_s) begin
                pend_r <= 1'b0;
            end
            cfg_ready <= xfer_s ? 1'b0 : ~pend_r;
            if (apply_s) begin
                thr_out <= pend_thr_r;
                en_out  <= pend_en_r;
            end
            stat_valid <= stat_load_s;
            if (stat_load_s) begin
                stat_edges  <= edge_cnt_r;
                stat_width  <= width_r;
                stat_height <= line_cnt_r;
            end
            err_geom    <= geom_evt_s | (err_geom & ~err_clr);
            err_timeout <= tmo_evt_s  | (err_timeout & ~err_clr);
        end
    end

endmodule
